// File: rtl/q1_path_sequencer.sv
// Drives q1's 2-bit input to walk it along the shortest legal path to a requested state.
// Optional `STATE_CHECK_EN: compare q1's observed state to the shadow model and resync on mismatch.
module q1_path_sequencer #(
  parameter int TIMEOUT = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [2:0] req_target,
  output logic       req_ready,
  output logic [1:0] fsm_in,
  input  logic [2:0] fsm_state,
  output logic       done,
  output logic [1:0] hops,
  output logic       err
);

  localparam logic [2:0] ST_A = 3'd0;
  localparam logic [2:0] ST_B = 3'd1;
  localparam logic [2:0] ST_C = 3'd2;
  localparam logic [2:0] ST_D = 3'd3;
  localparam logic [2:0] ST_E = 3'd4;
  localparam logic [2:0] TIMEOUT_C = 3'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, RUN, DONE} ctrl_t;

  ctrl_t      r_ctrl, w_ctrl_next;
  logic [2:0] r_shadow, w_shadow_next;
  logic [2:0] r_tgt, w_tgt_next;
  logic [2:0] r_cnt, w_cnt_next;
  logic [1:0] r_hops, w_hops_next;
  logic       r_err, w_err_next;
  logic [1:0] w_fsm_in;
  logic [2:0] w_pred;
  logic       w_mismatch;

  // Codes not listed for a state leave q1 where it is.
  function automatic logic [2:0] f_next(input logic [2:0] s, input logic [1:0] c);
    f_next = s;
    case (s)
      ST_A: if (c == 2'b01) f_next = ST_B; else if (c == 2'b10) f_next = ST_D;
      ST_B: if (c == 2'b00) f_next = ST_A;
      ST_C: if (c == 2'b11) f_next = ST_B; else if (c == 2'b01) f_next = ST_E;
      ST_D: if (c == 2'b00) f_next = ST_C;
      ST_E: if (c == 2'b11) f_next = ST_D;
      default: f_next = s;
    endcase
  endfunction

  function automatic logic [1:0] f_hold(input logic [2:0] s);
    f_hold = (s == ST_A) ? 2'b11 : 2'b00;
  endfunction

  function automatic logic [1:0] f_hop(input logic [2:0] s, input logic [2:0] t);
    f_hop = 2'b00;
    case (s)
      ST_A:    f_hop = (t == ST_B) ? 2'b01 : 2'b10;
      ST_C:    f_hop = (t == ST_A || t == ST_B) ? 2'b11 : 2'b01;
      ST_E:    f_hop = 2'b11;
      default: f_hop = 2'b00;
    endcase
  endfunction

`ifdef STATE_CHECK_EN
  assign w_mismatch = (fsm_state != r_shadow);
`else
  logic w_unused_state;
  assign w_unused_state = ^fsm_state;
  assign w_mismatch     = 1'b0;
`endif

  // Hop only while short of the target; a resync can land the shadow on it mid-RUN.
  assign w_fsm_in = (r_ctrl == RUN && r_shadow != r_tgt) ? f_hop(r_shadow, r_tgt)
                                                          : f_hold(r_shadow);
  assign w_pred   = f_next(r_shadow, w_fsm_in);

  always_comb begin
    w_ctrl_next   = r_ctrl;
    w_shadow_next = w_mismatch ? fsm_state : w_pred;
    w_tgt_next    = r_tgt;
    w_cnt_next    = r_cnt;
    w_hops_next   = r_hops;
    w_err_next    = w_mismatch;
    case (r_ctrl)
      IDLE: begin
        if (req_valid) begin
          if (req_target > ST_E) begin
            w_err_next = 1'b1;
          end else begin
            w_tgt_next = req_target;
            w_cnt_next = 3'd0;
            if (!w_mismatch && req_target == w_pred) begin
              w_ctrl_next = DONE;
              w_hops_next = 2'd0;
            end else begin
              w_ctrl_next = RUN;
            end
          end
        end
      end
      RUN: begin
        w_cnt_next = r_cnt + 3'd1;
        if (!w_mismatch && (w_pred == r_tgt || r_shadow == r_tgt)) begin
          w_ctrl_next = DONE;
          w_hops_next = w_cnt_next[1:0];
        end else if (w_cnt_next >= TIMEOUT_C) begin
          w_err_next  = 1'b1;
          w_ctrl_next = IDLE;
        end
      end
      DONE:    w_ctrl_next = IDLE;
      default: w_ctrl_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl   <= IDLE;
      r_shadow <= ST_A;
      r_tgt    <= ST_A;
      r_cnt    <= 3'd0;
      r_hops   <= 2'd0;
      r_err    <= 1'b0;
    end else begin
      r_ctrl   <= w_ctrl_next;
      r_shadow <= w_shadow_next;
      r_tgt    <= w_tgt_next;
      r_cnt    <= w_cnt_next;
      r_hops   <= w_hops_next;
      r_err    <= w_err_next;
    end
  end

  assign fsm_in    = w_fsm_in;
  assign req_ready = (r_ctrl == IDLE) && !reset;
  assign done      = (r_ctrl == DONE);
  assign hops      = r_hops;
  assign err       = r_err;

endmodule

// File: tb/tb_q1_path_sequencer.sv
// Bench for q1_path_sequencer: a q1 model feeds fsm_state; request vectors from a table,
// expected hop codes queued on request and popped cycle by cycle.
module tb_q1_path_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [2:0] req_target;
  logic       req_ready;
  logic [1:0] fsm_in;
  logic [2:0] fsm_state;
  logic       done;
  logic [1:0] hops;
  logic       err;

  logic [2:0] q1_state;
  logic       force_en;
  logic [2:0] force_val;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0] tgt;
    int         ncodes;
    logic [1:0] c0, c1, c2;
    logic [1:0] exp_hops;
    logic [1:0] park;
    logic       is_err;
  } vec_t;

  vec_t       vecs[14];
  logic [1:0] exp_q[$];

  q1_path_sequencer dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_target(req_target),
    .req_ready(req_ready), .fsm_in(fsm_in), .fsm_state(fsm_state),
    .done(done), .hops(hops), .err(err)
  );

  always #5 clk = ~clk;

  // Reference q1 transition table.
  function automatic logic [2:0] q1_next(input logic [2:0] s, input logic [1:0] c);
    logic [2:0] n;
    n = s;
    if (s == 3'd0 && c == 2'b01) n = 3'd1;
    if (s == 3'd0 && c == 2'b10) n = 3'd3;
    if (s == 3'd1 && c == 2'b00) n = 3'd0;
    if (s == 3'd2 && c == 2'b11) n = 3'd1;
    if (s == 3'd2 && c == 2'b01) n = 3'd4;
    if (s == 3'd3 && c == 2'b00) n = 3'd2;
    if (s == 3'd4 && c == 2'b11) n = 3'd3;
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) q1_state <= 3'd0;
    else       q1_state <= q1_next(q1_state, fsm_in);
  end

  assign fsm_state = force_en ? force_val : q1_state;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [1:0] code;
    check($sformatf("v%0d ready_before", idx), 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_target = v.tgt;
    if (v.ncodes > 0) exp_q.push_back(v.c0);
    if (v.ncodes > 1) exp_q.push_back(v.c1);
    if (v.ncodes > 2) exp_q.push_back(v.c2);
    tick();
    req_valid = 1'b0;
    if (v.is_err) begin
      check($sformatf("v%0d err_pulse", idx), 32'(err), 32'd1);
      check($sformatf("v%0d err_no_done", idx), 32'(done), 32'd0);
      check($sformatf("v%0d err_fsm_in", idx), 32'(fsm_in), 32'(v.park));
      check($sformatf("v%0d err_ready", idx), 32'(req_ready), 32'd1);
      tick();
      check($sformatf("v%0d err_cleared", idx), 32'(err), 32'd0);
    end else begin
      while (exp_q.size() > 0) begin
        code = exp_q.pop_front();
        check($sformatf("v%0d hop_code", idx), 32'(fsm_in), 32'(code));
        check($sformatf("v%0d no_early_done", idx), 32'(done), 32'd0);
        tick();
      end
      check($sformatf("v%0d done", idx), 32'(done), 32'd1);
      check($sformatf("v%0d hops", idx), 32'(hops), 32'(v.exp_hops));
      check($sformatf("v%0d park_code", idx), 32'(fsm_in), 32'(v.park));
      check($sformatf("v%0d ready_in_done", idx), 32'(req_ready), 32'd0);
      check($sformatf("v%0d no_err", idx), 32'(err), 32'd0);
      tick();
      check($sformatf("v%0d done_cleared", idx), 32'(done), 32'd0);
      check($sformatf("v%0d hops_held", idx), 32'(hops), 32'(v.exp_hops));
    end
    $display("request %0d: target=%0d hops=%0d err=%0b", idx, v.tgt, hops, v.is_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // {target, #codes, c0, c1, c2, hops, code while done/err, illegal}
    vecs[0]  = '{3'd4, 3, 2'b10, 2'b00, 2'b01, 2'd3, 2'b00, 1'b0}; // A->E
    vecs[1]  = '{3'd1, 3, 2'b11, 2'b00, 2'b11, 2'd3, 2'b00, 1'b0}; // E->B, drains to A
    vecs[2]  = '{3'd0, 0, 2'b00, 2'b00, 2'b00, 2'd0, 2'b11, 1'b0}; // A->A
    vecs[3]  = '{3'd6, 0, 2'b00, 2'b00, 2'b00, 2'd0, 2'b11, 1'b1}; // illegal at A
    vecs[4]  = '{3'd3, 1, 2'b10, 2'b00, 2'b00, 2'd1, 2'b00, 1'b0}; // A->D, drains to C
    vecs[5]  = '{3'd2, 0, 2'b00, 2'b00, 2'b00, 2'd0, 2'b00, 1'b0}; // C->C
    vecs[6]  = '{3'd0, 2, 2'b11, 2'b00, 2'b00, 2'd2, 2'b11, 1'b0}; // C->A
    vecs[7]  = '{3'd2, 2, 2'b10, 2'b00, 2'b00, 2'd2, 2'b00, 1'b0}; // A->C
    vecs[8]  = '{3'd1, 1, 2'b11, 2'b00, 2'b00, 2'd1, 2'b00, 1'b0}; // C->B, drains to A
    vecs[9]  = '{3'd7, 0, 2'b00, 2'b00, 2'b00, 2'd0, 2'b11, 1'b1}; // illegal at A
    vecs[10] = '{3'd4, 3, 2'b10, 2'b00, 2'b01, 2'd3, 2'b00, 1'b0}; // A->E
    vecs[11] = '{3'd4, 0, 2'b00, 2'b00, 2'b00, 2'd0, 2'b00, 1'b0}; // E->E
    vecs[12] = '{3'd3, 1, 2'b11, 2'b00, 2'b00, 2'd1, 2'b00, 1'b0}; // E->D, drains to C
    vecs[13] = '{3'd5, 0, 2'b00, 2'b00, 2'b00, 2'd0, 2'b00, 1'b1}; // illegal at C

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_target = 3'd0;
    force_en   = 1'b0;
    force_val  = 3'd0;
    tick();
    tick();
    check("rst fsm_in", 32'(fsm_in), 32'd3);
    check("rst ready", 32'(req_ready), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst err", 32'(err), 32'd0);
    check("rst hops", 32'(hops), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle fsm_in", 32'(fsm_in), 32'd3);
      check("idle ready", 32'(req_ready), 32'd1);
      check("idle q1 parked A", 32'(q1_state), 32'd0);
    end

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);
    check("q1 parked C", 32'(q1_state), 32'd2);

    // Reset in the middle of a C->A walk, after its first hop edge.
    req_valid  = 1'b1;
    req_target = 3'd0;
    tick();
    req_valid = 1'b0;
    check("mid first hop", 32'(fsm_in), 32'd3);
    tick();
    check("mid second hop", 32'(fsm_in), 32'd0);
    reset = 1'b1;
    #1;
    check("mid rst fsm_in", 32'(fsm_in), 32'd3);
    check("mid rst ready", 32'(req_ready), 32'd0);
    check("mid rst done", 32'(done), 32'd0);
    check("mid rst err", 32'(err), 32'd0);
    check("mid rst hops", 32'(hops), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    $display("request mid-run reset: outputs returned to reset values");
    run_vec('{3'd3, 1, 2'b10, 2'b00, 2'b00, 2'd1, 2'b00, 1'b0}, 14);

`ifdef STATE_CHECK_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    force_val = 3'd2;
    force_en  = 1'b1;
    tick();
    check("resync err", 32'(err), 32'd1);
    check("resync fsm_in", 32'(fsm_in), 32'd0);
    tick();
    check("resync err cleared", 32'(err), 32'd0);
    check("resync hold C", 32'(fsm_in), 32'd0);
    $display("request resync: forced fsm_state=C");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
